alu_cmd_driver: RTL and testbench
=================================

// Module: alu_cmd_driver
//
// PURPOSE
// Command-side driver for the 4-bit, 8-function ALU: collects an opcode and operands
// as 4-bit beats over a valid/ready input, registers them onto the ALU's A/B/Function
// pins, waits a fixed settle time, then captures ALUout and presents it over a
// valid/ready result port. An optional chain flag reuses the previous result's low
// nibble as operand A, so the team can run accumulate-style sequences from switches/keys.
//
// PARAMETERS
// DATA_W   4   operand width; ALU A/B width
// OP_W     3   ALU function-select width
// ALU_LAT  2   cycles between driving ALU pins and capturing ALUout (>=1)
//
// PORTS
// Clock       in   1          rising-edge clock
// Reset_b     in   1          asynchronous, active-low reset
// in_data     in   DATA_W     command beat (opcode beat / operand A / operand B)
// in_valid    in   1          in_data valid
// in_ready    out  1          block accepts beat; beat taken when in_valid&&in_ready
// alu_a       out  DATA_W     to ALU A (registered)
// alu_b       out  DATA_W     to ALU B (registered)
// alu_func    out  OP_W       to ALU Function (registered)
// alu_result  in   2*DATA_W   from ALU ALUout
// res_data    out  2*DATA_W   captured result
// res_err     out  1          captured opcode was 110/111 (undefined function)
// res_valid   out  1          res_data/res_err valid
// res_ready   in   1          consumer accepts result
// busy        out  1          high in any state except S_OP
//
// BEHAVIOUR
// - Reset (Reset_b=0, async): state=S_OP; alu_a, alu_b, alu_func, res_data, res_err,
//   res_valid, busy, last_res, chain_q, lat_cnt all 0; in_ready=1 once reset released.
// - Opcode beat: in_data[OP_W-1:0]=opcode, in_data[DATA_W-1]=chain flag.
// - FSM (one transition per accepted beat / condition, evaluated at rising edge):
//   S_OP   in_ready=1. Accept -> latch opcode, chain_q; chain_q=1 ? S_B : S_A.
//          On chain, alu_a <= last_res[DATA_W-1:0] at the same edge.
//   S_A    in_ready=1. Accept -> alu_a <= in_data; -> S_B.
//   S_B    in_ready=1. Accept -> alu_b <= in_data; alu_func <= opcode;
//          lat_cnt <= ALU_LAT-1; -> S_EXEC.
//   S_EXEC in_ready=0. lat_cnt!=0: decrement. lat_cnt==0: res_data <= alu_result,
//          last_res <= alu_result, res_err <= (opcode>=3'b110), res_valid <= 1; -> S_RES.
//   S_RES  in_ready=0. res_valid&&res_ready -> res_valid <= 0; -> S_OP.
// - Latency: B beat accepted at edge N -> ALU pins valid after N; capture at edge
//   N+ALU_LAT; res_valid high from that edge. Next opcode accepted >= 1 cycle after
//   result handshake (no overlap).
// - alu_a/alu_b/alu_func hold their values outside S_B/chain updates; never glitch.
// - res_data/res_err stable while res_valid=1 and res_ready=0 (backpressure, any length).
// - in_valid while in_ready=0 ignored; no beat lost or buffered.
// - Chain with no prior result uses last_res=0 (reset value).
// - Undefined opcodes still executed; result is whatever ALU returns (expected 0);
//   res_err=1 flags it. last_res updated regardless.
// - Reset asserted mid-command or mid-EXEC: all state cleared, partial command dropped,
//   res_valid falls asynchronously.
// - busy = (state != S_OP).
//
// TESTING
// 1 op 000, A=3, B=1, ALU_LAT=2 -> res_data=8'h04 exactly 2 cycles after B beat, res_err=0.
// 2 op 101, A=3, B=5 -> res_data=8'h53; then chained op 001 (beat 4'b1001), B=2 ->
//   no A beat, alu_a=3, res_data=8'h05.
// 3 op 010, A=7, B=9 with res_ready=0 for 10 cycles -> res_data=8'h09 held, in_ready=0,
//   extra in_valid beats ignored; res_ready=1 -> res_valid drops next edge, in_ready=1.
// 4 op 111, A=F, B=F -> res_data=8'h00, res_err=1; next op 100, A=F, B=F -> 8'h01, res_err=0.
// 5 Reset_b pulsed low during S_EXEC -> all outputs 0 immediately, state S_OP; fresh
//   op 011, A=0, B=0 -> res_data=8'h00.
// 6 Chain as first command after reset (beat 4'b1000), B=6 -> alu_a=0, res_data=8'h06.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// Collects opcode/A/B beats, drives the ALU pins, captures ALUout after ALU_LAT cycles.
// Input is stalled (in_ready=0) from the B beat until the result handshake completes.
module alu_cmd_driver #(
  parameter int DATA_W  = 4,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 2
) (
  input  logic                Clock,
  input  logic                Reset_b,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_func,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic [2*DATA_W-1:0] res_data,
  output logic                res_err,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                busy
);

  localparam logic [2:0] S_OP   = 3'd0;
  localparam logic [2:0] S_A    = 3'd1;
  localparam logic [2:0] S_B    = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_RES  = 3'd4;

  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  logic [2:0]        state;
  logic [OP_W-1:0]   op_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] last_res;

  assign in_ready = (state == S_OP) || (state == S_A) || (state == S_B);
  assign busy     = (state != S_OP);

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state     <= S_OP;
      op_q      <= '0;
      lat_cnt   <= '0;
      last_res  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_func  <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_OP: if (in_valid) begin
          op_q <= in_data[OP_W-1:0];
          // Chain flag: previous result's low nibble becomes A, so no A beat follows.
          if (in_data[DATA_W-1]) begin
            alu_a <= last_res;
            state <= S_B;
          end else begin
            state <= S_A;
          end
        end
        S_A: if (in_valid) begin
          alu_a <= in_data;
          state <= S_B;
        end
        S_B: if (in_valid) begin
          alu_b    <= in_data;
          alu_func <= op_q;
          lat_cnt  <= LAT_W'(ALU_LAT - 1);
          state    <= S_EXEC;
        end
        S_EXEC: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else begin
            res_data  <= alu_result;
            last_res  <= alu_result[DATA_W-1:0];
            res_err   <= (op_q >= OP_W'(6));
            res_valid <= 1'b1;
            state     <= S_RES;
          end
        end
        S_RES: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= S_OP;
        end
        default: state <= S_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Randomized + directed bench for alu_cmd_driver with a queue scoreboard and a stand-in ALU.
module tb_alu_cmd_driver;
  localparam int DW  = 4;
  localparam int OW  = 3;
  localparam int LAT = 2;

  logic          Clock = 1'b0;
  logic          Reset_b;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_a, alu_b;
  logic [OW-1:0] alu_func;
  logic [2*DW-1:0] alu_result, res_data;
  logic          res_err, res_valid, res_ready, busy;

  alu_cmd_driver #(.DATA_W(DW), .OP_W(OW), .ALU_LAT(LAT)) dut (
    .Clock(Clock), .Reset_b(Reset_b), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_result(alu_result), .res_data(res_data), .res_err(res_err),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  always #5 Clock = ~Clock;

  // Stand-in for the 8-function ALU; 110/111 are undefined and return 0.
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0, 3'd1: return 8'(a) + 8'(b);
      3'd2:       return (a > b) ? 8'(a) : 8'(b);
      3'd3:       return 8'(a) * 8'(b);
      3'd4:       return (a == b) ? 8'd1 : 8'd0;
      3'd5:       return {b, a};
      default:    return 8'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_func, alu_a, alu_b);

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         b_cyc;
  } exp_t;

  exp_t       q[$];
  logic [3:0] last_m;
  int         cyc = 0;
  int         rr_mode = 1;
  int         tests = 0;
  int         fails = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(posedge Clock) begin
    #1;
    case (rr_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle a result is presented it must match the oldest expectation.
  logic prev_v = 1'b0;
  always @(negedge Clock) begin
    if (!Reset_b) begin
      prev_v = 1'b0;
    end else if (res_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %0h expected none", res_data);
        prev_v = 1'b0;
      end else begin
        if (!prev_v) check("latency", cyc, q[0].b_cyc + LAT);
        check("res_data", 32'(res_data), 32'(q[0].data));
        check("res_err", 32'(res_err), 32'(q[0].err));
        check("busy_res", 32'(busy), 32'd1);
        if (res_ready) void'(q.pop_front());
        prev_v = !res_ready;
      end
    end else begin
      prev_v = 1'b0;
    end
  end

  // Call at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [3:0] d, output int acc_cyc);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge Clock);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL beat_timeout: in_ready stuck 0 expected 1");
        break;
      end
    end
    acc_cyc = cyc + 1;
    @(posedge Clock);
    #1;
    in_valid = 1'b0;
    in_data  = 4'($urandom);
  endtask

  task automatic send_cmd(input logic chain, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int         c;
    logic [3:0] ea;
    exp_t       e;
    send_beat({chain, op}, c);
    if (!chain) send_beat(a, c);
    ea = chain ? last_m : a;
    send_beat(b, c);
    check("alu_a", 32'(alu_a), 32'(ea));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_func", 32'(alu_func), 32'(op));
    check("in_ready_exec", 32'(in_ready), 32'd0);
    e.data  = alu_fn(op, ea, b);
    e.err   = (op >= 3'd6);
    e.b_cyc = c;
    q.push_back(e);
    last_m = e.data[3:0];
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge Clock);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: %0d results pending expected 0", q.size());
      q.delete();
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int c;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b1;
    last_m    = '0;
    Reset_b   = 1'b0;
    #12;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_alu_pins", 32'({alu_a, alu_b, alu_func}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge Clock);
    Reset_b = 1'b1;
    @(posedge Clock);
    #1;
    check("in_ready_idle", 32'(in_ready), 32'd1);

    send_cmd(1'b1, 3'd0, 4'd0, 4'd6);          // chain straight after reset: A=0
    send_cmd(1'b0, 3'd0, 4'd3, 4'd1);
    send_cmd(1'b0, 3'd5, 4'd3, 4'd5);
    send_cmd(1'b1, 3'd1, 4'd0, 4'd2);          // A comes from 8'h53
    send_cmd(1'b0, 3'd7, 4'hF, 4'hF);
    send_cmd(1'b0, 3'd4, 4'hF, 4'hF);
    wait_idle();

    // Long backpressure with junk beats offered while in_ready is low.
    rr_mode = 0;
    send_cmd(1'b0, 3'd2, 4'd7, 4'd9);
    repeat (10) begin
      @(negedge Clock);
      in_valid = 1'b1;
      in_data  = 4'($urandom);
      check("in_ready_stall", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    rr_mode  = 1;
    wait_idle();
    check("res_valid_drop", 32'(res_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);

    // Reset in the middle of EXEC: the partial command must vanish.
    send_beat(4'b0010, c);
    send_beat(4'd5, c);
    send_beat(4'd6, c);
    Reset_b = 1'b0;
    #1;
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_alu_pins", 32'({alu_a, alu_b, alu_func}), 32'd0);
    check("mid_rst_res", 32'({res_data, res_err}), 32'd0);
    last_m = '0;
    @(negedge Clock);
    Reset_b = 1'b1;
    @(posedge Clock);
    #1;
    send_cmd(1'b0, 3'd3, 4'd0, 4'd0);
    send_cmd(1'b1, 3'd0, 4'd0, 4'd1);
    wait_idle();

    rr_mode = 2;
    repeat (40) begin
      send_cmd(1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), 4'($urandom));
    end
    rr_mode = 1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
